// File: rtl/fifo_pkg.sv
// Shared definitions for the write- and read-side pointer controllers of the async FIFO:
// default geometry and Gray/binary conversion helpers.
package fifo_pkg;

  localparam int unsigned DefaultAddrLen    = 8;
  localparam int unsigned DefaultSyncStages = 2;

  // Widest pointer the helpers handle; callers zero-extend into this and truncate the result.
  localparam int unsigned PtrMaxW = 32;
  typedef logic [PtrMaxW-1:0] ptr_word_t;

  function automatic ptr_word_t width_mask(input int unsigned width);
    ptr_word_t mask;
    if (width >= PtrMaxW) begin
      mask = '1;
    end else begin
      mask = (ptr_word_t'(1) << width) - ptr_word_t'(1);
    end
    return mask;
  endfunction

  function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int unsigned width);
    ptr_word_t b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int unsigned width);
    ptr_word_t g;
    ptr_word_t bin;
    g   = gray & width_mask(width);
    bin = '0;
    for (int i = 0; i < PtrMaxW; i++) begin
      bin[i] = ^(g >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/wptr_ctrl_sync_if.sv
// Write-client / memory / pointer-crossing signals of the write-side pointer controller.
// The controller uses the slave modport; the client side uses master.
interface wptr_ctrl_sync_if #(
  parameter int unsigned ADDR_LEN = fifo_pkg::DefaultAddrLen
) ();

  logic                wincr_i;
  logic [ADDR_LEN:0]   rptr_gray_i;
  logic [ADDR_LEN:0]   afull_thresh_i;
  logic                wovf_clr_i;
  logic                fifo_wen_o;
  logic [ADDR_LEN-1:0] fifo_waddr_o;
  logic [ADDR_LEN:0]   wptr_o;
  logic                wfull_o;
  logic                walmost_full_o;
  logic [ADDR_LEN:0]   wlevel_o;
  logic                wovf_o;

  modport slave (
    input  wincr_i,
    input  rptr_gray_i,
    input  afull_thresh_i,
    input  wovf_clr_i,
    output fifo_wen_o,
    output fifo_waddr_o,
    output wptr_o,
    output wfull_o,
    output walmost_full_o,
    output wlevel_o,
    output wovf_o
  );

  modport master (
    output wincr_i,
    output rptr_gray_i,
    output afull_thresh_i,
    output wovf_clr_i,
    input  fifo_wen_o,
    input  fifo_waddr_o,
    input  wptr_o,
    input  wfull_o,
    input  walmost_full_o,
    input  wlevel_o,
    input  wovf_o
  );

endinterface

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for a Gray-coded bus; every stage resets to zero.
// Shared by the write- and read-side pointer controllers.
module sync_ff_chain #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/wptr_ctrl_sync.sv
// Write-side pointer controller of the async FIFO: write pointer, full/almost-full flags,
// fill level and sticky overflow, all in the wclk domain against a synchronised read pointer.
module wptr_ctrl_sync import fifo_pkg::*; #(
  parameter int unsigned ADDR_LEN    = DefaultAddrLen,
  parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
  input logic             wclk,
  input logic             wrst_n,
  wptr_ctrl_sync_if.slave bus
);

  localparam int unsigned PtrW = ADDR_LEN + 1;
  typedef logic [PtrW-1:0] ptr_t;

  ptr_t wbin_q;
  ptr_t wbin_next;
  ptr_t wgray_next;
  ptr_t wptr_q;
  ptr_t rq;
  ptr_t rbin;
  ptr_t rq_full_pattern;
  ptr_t level_next;
  ptr_t wlevel_q;

  logic fifo_wen;
  logic wfull_q;
  logic wfull_d;
  logic walmost_full_q;
  logic walmost_full_d;
  logic wovf_q;
  logic wovf_d;

  sync_ff_chain #(
    .WIDTH  (PtrW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk_i  (wclk),
    .rst_ni (wrst_n),
    .d_i    (bus.rptr_gray_i),
    .q_o    (rq)
  );

  always_comb begin
    fifo_wen   = bus.wincr_i & ~wfull_q;
    wbin_next  = wbin_q + ptr_t'(fifo_wen);
    wgray_next = ptr_t'(bin2gray(ptr_word_t'(wbin_next), PtrW));
    rbin       = ptr_t'(gray2bin(ptr_word_t'(rq), PtrW));

    // Full when the write pointer is exactly one lap ahead of the (stale) read pointer.
    rq_full_pattern = {~rq[ADDR_LEN:ADDR_LEN-1], rq[ADDR_LEN-2:0]};
    wfull_d         = (wgray_next == rq_full_pattern);

    level_next     = wbin_next - rbin;
    walmost_full_d = (level_next >= bus.afull_thresh_i);

    // A new drop takes priority over a clear in the same cycle.
    wovf_d = (bus.wincr_i & wfull_q) | (wovf_q & ~bus.wovf_clr_i);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q         <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_next;
      wptr_q         <= wgray_next;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= level_next;
      wovf_q         <= wovf_d;
    end
  end

  assign bus.fifo_wen_o     = fifo_wen;
  assign bus.fifo_waddr_o   = wbin_q[ADDR_LEN-1:0];
  assign bus.wptr_o         = wptr_q;
  assign bus.wfull_o        = wfull_q;
  assign bus.walmost_full_o = walmost_full_q;
  assign bus.wlevel_o       = wlevel_q;
  assign bus.wovf_o         = wovf_q;

endmodule

// File: tb/tb_wptr_ctrl_sync.sv
// Bench for wptr_ctrl_sync (ADDR_LEN=3, SYNC_STAGES=2): directed table, hand sequences for
// reset/drain/wrap, then random traffic against a count-based reference model.
module tb_wptr_ctrl_sync;

  localparam int unsigned ADDR_LEN    = 3;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int          Depth       = 8;

  logic wclk = 1'b0;
  logic wrst_n = 1'b0;

  always #5 wclk = ~wclk;

  wptr_ctrl_sync_if #(.ADDR_LEN(ADDR_LEN)) bus ();

  wptr_ctrl_sync #(
    .ADDR_LEN    (ADDR_LEN),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         wincr;
    int         clr;
    int         exp_wen;
    int         exp_waddr;
    logic [3:0] exp_wptr;
    int         exp_full;
    int         exp_alm;
    int         exp_level;
    int         exp_ovf;
  } vec_t;

  vec_t tbl[13];

  // Reference model: total accepted writes and read counts, delayed by the crossing latency.
  int m_wcount;
  int m_level;
  bit m_full;
  bit m_alm;
  bit m_ovf;
  int rdel[$];

  function automatic logic [3:0] gray4(input int v);
    logic [3:0] b;
    b = v[3:0];
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wen"},   32'(bus.fifo_wen_o),     0);
    check({tag, "_waddr"}, 32'(bus.fifo_waddr_o),   0);
    check({tag, "_wptr"},  32'(bus.wptr_o),         0);
    check({tag, "_full"},  32'(bus.wfull_o),        0);
    check({tag, "_alm"},   32'(bus.walmost_full_o), 0);
    check({tag, "_level"}, 32'(bus.wlevel_o),       0);
    check({tag, "_ovf"},   32'(bus.wovf_o),         0);
  endtask

  task automatic drive(input bit wincr, input bit clr, input logic [3:0] rg,
                       input logic [3:0] th);
    @(negedge wclk);
    bus.wincr_i        = wincr;
    bus.wovf_clr_i     = clr;
    bus.rptr_gray_i    = rg;
    bus.afull_thresh_i = th;
    #1;
  endtask

  task automatic edge1();
    @(posedge wclk);
    #1;
  endtask

  // Asserts reset between edges, checks outputs collapse at once, releases on a falling edge.
  task automatic do_reset(input string tag);
    @(posedge wclk);
    #3;
    bus.wincr_i     = 1'b0;
    bus.wovf_clr_i  = 1'b0;
    bus.rptr_gray_i = 4'b0000;
    wrst_n          = 1'b0;
    #1;
    check_zero(tag);
    @(negedge wclk);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  task automatic model_reset();
    m_wcount = 0;
    m_level  = 0;
    m_full   = 1'b0;
    m_alm    = 1'b0;
    m_ovf    = 1'b0;
    rdel.delete();
    for (int i = 0; i < int'(SYNC_STAGES); i++) rdel.push_back(0);
  endtask

  task automatic model_edge(input bit wincr, input bit clr, input int rcount, input int thresh);
    int rvis;
    bit wen;
    wen      = wincr && !m_full;
    m_ovf    = (wincr && m_full) || (m_ovf && !clr);
    m_wcount = m_wcount + int'(wen);
    rvis     = rdel.pop_front();
    rdel.push_back(rcount);
    m_level  = m_wcount - rvis;
    m_full   = (m_level == Depth);
    m_alm    = (m_level >= thresh);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] prev;
    logic [3:0] th;
    int         wc;
    int         rc;
    bit         wi;
    bit         cl;
    bit         seen_wrap;

    //            wincr clr wen waddr wptr     full alm level ovf
    tbl[0]  = '{1, 0, 1, 0, 4'b0001, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 1, 1, 4'b0011, 0, 0, 2, 0};
    tbl[2]  = '{1, 0, 1, 2, 4'b0010, 0, 0, 3, 0};
    tbl[3]  = '{1, 0, 1, 3, 4'b0110, 0, 0, 4, 0};
    tbl[4]  = '{1, 0, 1, 4, 4'b0111, 0, 0, 5, 0};
    tbl[5]  = '{1, 0, 1, 5, 4'b0101, 0, 1, 6, 0};
    tbl[6]  = '{1, 0, 1, 6, 4'b0100, 0, 1, 7, 0};
    tbl[7]  = '{1, 0, 1, 7, 4'b1100, 1, 1, 8, 0};
    tbl[8]  = '{1, 0, 0, 0, 4'b1100, 1, 1, 8, 1};  // write while full is dropped
    tbl[9]  = '{0, 1, 0, 0, 4'b1100, 1, 1, 8, 0};  // clear alone
    tbl[10] = '{1, 0, 0, 0, 4'b1100, 1, 1, 8, 1};
    tbl[11] = '{1, 1, 0, 0, 4'b1100, 1, 1, 8, 1};  // set beats clear
    tbl[12] = '{0, 0, 0, 0, 4'b1100, 1, 1, 8, 1};  // sticky

    bus.wincr_i        = 1'b0;
    bus.wovf_clr_i     = 1'b0;
    bus.rptr_gray_i    = 4'b0000;
    bus.afull_thresh_i = 4'd6;

    // Power-on reset, then a mid-cycle reset after a couple of writes.
    do_reset("por");
    edge1();
    check("por_release_full",  32'(bus.wfull_o),  0);
    check("por_release_level", 32'(bus.wlevel_o), 0);
    drive(1'b1, 1'b0, 4'b0000, 4'd6);
    edge1();
    drive(1'b1, 1'b0, 4'b0000, 4'd6);
    edge1();
    check("pre_reset_level", 32'(bus.wlevel_o), 2);
    do_reset("midclk_reset");

    // Fill to full and exercise overflow set/clear.
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].wincr[0], tbl[i].clr[0], 4'b0000, 4'd6);
      check($sformatf("tbl%0d_wen", i),   32'(bus.fifo_wen_o),     tbl[i].exp_wen);
      check($sformatf("tbl%0d_waddr", i), 32'(bus.fifo_waddr_o),   tbl[i].exp_waddr);
      edge1();
      check($sformatf("tbl%0d_wptr", i),  32'(bus.wptr_o),         int'(tbl[i].exp_wptr));
      check($sformatf("tbl%0d_full", i),  32'(bus.wfull_o),        tbl[i].exp_full);
      check($sformatf("tbl%0d_alm", i),   32'(bus.walmost_full_o), tbl[i].exp_alm);
      check($sformatf("tbl%0d_level", i), 32'(bus.wlevel_o),       tbl[i].exp_level);
      check($sformatf("tbl%0d_ovf", i),   32'(bus.wovf_o),         tbl[i].exp_ovf);
    end

    // Drain visibility: read pointer moves to 2, seen on the third edge only.
    drive(1'b0, 1'b0, 4'b0011, 4'd6);
    for (int e = 1; e <= 3; e++) begin
      edge1();
      check($sformatf("drain_e%0d_full", e),  32'(bus.wfull_o),  (e < 3) ? 1 : 0);
      check($sformatf("drain_e%0d_level", e), 32'(bus.wlevel_o), (e < 3) ? 8 : 6);
    end
    check("drain_alm", 32'(bus.walmost_full_o), 1);

    // Reset mid-fill at level 5.
    do_reset("pre_midfill");
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 4'b0000, 4'd6);
      edge1();
    end
    check("midfill_level", 32'(bus.wlevel_o), 5);
    do_reset("midfill_reset");
    drive(1'b1, 1'b0, 4'b0000, 4'd6);
    check("midfill_restart_wen",   32'(bus.fifo_wen_o),   1);
    check("midfill_restart_waddr", 32'(bus.fifo_waddr_o), 0);
    edge1();
    check("midfill_restart_waddr1", 32'(bus.fifo_waddr_o), 1);
    check("midfill_restart_wptr",   32'(bus.wptr_o),       1);
    check("midfill_restart_level",  32'(bus.wlevel_o),     1);

    // Wrap: 40 writes with the read pointer trailing by 3, threshold above depth.
    do_reset("pre_wrap");
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'b0000, 4'd9);
      edge1();
    end
    wc        = 3;
    seen_wrap = 1'b0;
    for (int k = 0; k < 40; k++) begin
      prev = bus.wptr_o;
      drive(1'b1, 1'b0, gray4(wc - 3), 4'd9);
      edge1();
      wc++;
      check("wrap_onebit", 32'($countones(prev ^ bus.wptr_o)), 1);
      check("wrap_wptr", 32'(bus.wptr_o), int'(gray4(wc)));
      if (prev == 4'b1000) begin
        check("wrap_1000_to_0000", 32'(bus.wptr_o), 0);
        seen_wrap = 1'b1;
      end
      drive(1'b0, 1'b0, gray4(wc - 3), 4'd9);
      for (int e = 0; e < 3; e++) begin
        edge1();
        check("wrap_full", 32'(bus.wfull_o), 0);
      end
      check("wrap_level", 32'(bus.wlevel_o),       3);
      check("wrap_alm",   32'(bus.walmost_full_o), 0);
    end
    check("wrap_seen", 32'(seen_wrap), 1);

    // Random traffic against the model, starting with threshold 0.
    bus.afull_thresh_i = 4'd0;
    th = 4'd0;
    do_reset("pre_random");
    model_reset();
    model_edge(1'b0, 1'b0, 0, 0);
    edge1();
    check("thresh0_first_edge", 32'(bus.walmost_full_o), int'(m_alm));
    rc = 0;
    for (int c = 0; c < 2000; c++) begin
      if (((c / 256) % 2) == 0) wi = ($urandom_range(0, 3) != 0);
      else                      wi = ($urandom_range(0, 3) == 0);
      cl = ($urandom_range(0, 7) == 0);
      if (rc < m_wcount && $urandom_range(0, 1) == 0) rc++;
      if ((c % 64) == 63) th = 4'($urandom_range(0, 15));
      drive(wi, cl, gray4(rc), th);
      check("rnd_wen",   32'(bus.fifo_wen_o),   int'(wi && !m_full));
      check("rnd_waddr", 32'(bus.fifo_waddr_o), m_wcount % Depth);
      edge1();
      model_edge(wi, cl, rc, int'(th));
      check("rnd_wptr",  32'(bus.wptr_o),         int'(gray4(m_wcount)));
      check("rnd_full",  32'(bus.wfull_o),        int'(m_full));
      check("rnd_alm",   32'(bus.walmost_full_o), int'(m_alm));
      check("rnd_level", 32'(bus.wlevel_o),       m_level);
      check("rnd_ovf",   32'(bus.wovf_o),         int'(m_ovf));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wptr_ctrl_sync.md
# wptr_ctrl_sync

Write-side pointer controller for the asynchronous FIFO. It generalises the basic write pointer block with:
- an internal, parametrised-depth read-pointer synchroniser;
- a registered fill level;
- a programmable almost-full flag;
- a sticky overflow flag;
- a qualified memory write enable.

It sits in the wclk domain between the write client, the dual-port FIFO memory and the read-pointer crossing.

## Interface
Parameters:
- ADDR_LEN, 8, memory address width; FIFO depth = 2^ADDR_LEN; legal range ≥ 2.
- SYNC_STAGES, 2, flops in the rptr→wclk synchroniser; legal range ≥ 2.

Ports:
- wclk  in  1  write clock.
- wrst_n  in  1  reset, asynchronous, active-low.
- wincr_i  in  1  write request.
- rptr_gray_i  in  ADDR_LEN+1  Gray read pointer from rclk domain (unsynchronised).
- afull_thresh_i  in  ADDR_LEN+1  almost-full threshold, quasi-static.
- wovf_clr_i  in  1  clears wovf_o.
- fifo_wen_o  out  1  memory write enable = wincr_i & ~wfull_o (combinational).
- fifo_waddr_o  out  ADDR_LEN  memory write address.
- wptr_o  out  ADDR_LEN+1  Gray write pointer to rclk domain, registered.
- wfull_o  out  1  FIFO full, registered.
- walmost_full_o  out  1  level ≥ threshold, registered.
- wlevel_o  out  ADDR_LEN+1  fill level 0..2^ADDR_LEN, registered.
- wovf_o  out  1  sticky overflow, registered.

## Operation
- wbin: binary counter, ADDR_LEN+1 bits.
  - wbin_next = wbin + fifo_wen_o, computed modulo 2^(ADDR_LEN+1).
  - fifo_waddr_o = wbin[ADDR_LEN-1:0].
- wptr_o <= wgray_next = (wbin_next >> 1) ^ wbin_next. wptr_o changes by exactly one bit per accepted write.
- Synchroniser: SYNC_STAGES-deep flop chain on rptr_gray_i; every stage resets to 0. rq = last stage output.
- rbin = Gray-to-binary of rq.
- wfull_o <= (wgray_next == {~rq[ADDR_LEN:ADDR_LEN-1], rq[ADDR_LEN-2:0]}).
- level_next = wbin_next − rbin, modulo 2^(ADDR_LEN+1).
  - wlevel_o <= level_next.
  - walmost_full_o <= (level_next ≥ afull_thresh_i).
- Overflow:
  - A write request while wfull_o=1 is dropped: no pointer or address change.
  - wovf_o sets on the next edge.
  - wovf_clr_i clears wovf_o; when set and clear occur in the same cycle, set wins.
- Level and flags are pessimistic. The read pointer is seen SYNC_STAGES+1 wclk edges late, so the FIFO is never overfilled.
- Reset, asynchronous, any time: wbin, all sync stages, wptr_o, wfull_o, walmost_full_o, wlevel_o and wovf_o go to 0. A write in flight at reset is lost.

## Timing
- Accepted write at edge N:
  - fifo_waddr_o and wptr_o reflect the new count after edge N.
  - wfull_o, wlevel_o and walmost_full_o reflect it after edge N.
- Read-pointer change at rptr_gray_i: flags and level update after SYNC_STAGES+1 wclk edges.
- Full boundary: the write that makes level = 2^ADDR_LEN asserts wfull_o on the same edge. The next request is blocked combinationally via fifo_wen_o.
- Wrap: wbin rolls over from 2^(ADDR_LEN+1)−1 to 0. Level arithmetic wraps with it and stays correct.
- Threshold 0: walmost_full_o = 1 from the first edge after reset.
- Threshold > 2^ADDR_LEN: walmost_full_o is never asserted.

## Structure
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions, parametrised by width;
  - default ADDR_LEN and SYNC_STAGES constants, shared with the read-side controller.
- One sub-module: sync_ff_chain (WIDTH, STAGES), a multi-flop synchroniser with async active-low reset. The read-side controller reuses it.

## Test plan
All scenarios use ADDR_LEN=3 and SYNC_STAGES=2.
- Reset: assert wrst_n=0 mid-clock → all outputs 0 immediately, fifo_waddr_o=0; release → wfull_o=0, wlevel_o=0.
- Fill: 8 back-to-back writes, rptr_gray_i=0, afull_thresh_i=6.
  - fifo_waddr_o steps 0..7.
  - walmost_full_o=1 after the 6th write.
  - After the 8th write: wfull_o=1, wlevel_o=8, wptr_o=4'b1100.
- Overflow: 9th write while full → fifo_wen_o=0, wptr_o/fifo_waddr_o unchanged, wovf_o=1. wovf_clr_i alone → 0. Clear with a simultaneous blocked write → stays 1.
- Drain visibility: from full, set rptr_gray_i=4'b0011 (binary 2) → wfull_o=0 and wlevel_o=6 exactly 3 wclk edges later, not earlier.
- Wrap: 40 writes with rptr_gray_i tracking at wptr lag 3 →
  - wptr_o has single-bit transitions throughout;
  - 4'b1000 → 4'b0000 at the wrap;
  - wlevel_o stays 3;
  - wfull_o never asserts.
- Reset mid-fill: level 5, assert wrst_n → all outputs 0; subsequent writes start at fifo_waddr_o=0.
